// File: rtl/smem_req_tracker.sv
// Per-core shared-memory request tracker: IDLE -> PEND -> DONE, with bank-routed finish and a timeout.
// Latency: accept edge N gives core_val in N+1; finish at edge M gives core_done in M+1 and core_ready in M+2.
// Backpressure: a core may issue only while core_ready is high; requests in PEND or DONE are dropped.
module smem_req_tracker #(
    parameter int NCORES  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCORES-1:0]        core_req,
    input  logic [NCORES-1:0]        core_we,
    input  logic [12*NCORES-1:0]     core_addr,
    input  logic [8*NCORES-1:0]      core_wdata,
    output logic [NCORES-1:0]        core_ready,
    output logic [NCORES-1:0]        core_done,
    output logic [NCORES-1:0]        core_err,
    output logic [8*NCORES-1:0]      core_rdata,
    output logic [NCORES-1:0]        core_val,
    output logic [NCORES-1:0]        read,
    output logic [NCORES-1:0]        write,
    output logic [12*NCORES-1:0]     addr_in,
    output logic [8*NCORES-1:0]      data_in,
    input  logic [16*NCORES-1:0]     bank_finish,
    input  logic [16*8*NCORES-1:0]   bank_data
);
    localparam int NBANKS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    for (genvar c = 0; c < NCORES; c++) begin : g_core
        state_e            state_q, state_d;
        logic [7:0]        wait_cnt_q, wait_cnt_d;
        logic              err_q, err_d;
        logic              we_q, we_d;
        logic [11:0]       addr_q, addr_d;
        logic [7:0]        wdata_q, wdata_d;
        logic [7:0]        rdata_q, rdata_d;
        logic [NBANKS-1:0] fin_vec;
        logic [7:0]        dat_vec [NBANKS];
        logic              fin;
        logic [7:0]        bank_byte;

        // Gather this core's finish bit and data byte from every bank, then pick the latched bank.
        for (genvar b = 0; b < NBANKS; b++) begin : g_bank
            assign fin_vec[b] = bank_finish[NCORES*b + c];
            assign dat_vec[b] = bank_data[8*NCORES*b + 8*c +: 8];
        end

        assign fin       = fin_vec[addr_q[11:8]];
        assign bank_byte = dat_vec[addr_q[11:8]];

        always_comb begin
            state_d    = state_q;
            wait_cnt_d = wait_cnt_q;
            err_d      = err_q;
            we_d       = we_q;
            addr_d     = addr_q;
            wdata_d    = wdata_q;
            rdata_d    = rdata_q;
            case (state_q)
                ST_IDLE: begin
                    if (core_req[c]) begin
                        state_d    = ST_PEND;
                        we_d       = core_we[c];
                        addr_d     = core_addr[12*c +: 12];
                        wdata_d    = core_wdata[8*c +: 8];
                        wait_cnt_d = 8'd0;
                    end
                end
                ST_PEND: begin
                    // Finish takes precedence over a simultaneous timeout.
                    if (fin) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        if (!we_q) begin
                            rdata_d = bank_byte;
                        end
                    end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q    <= ST_IDLE;
                wait_cnt_q <= 8'd0;
                err_q      <= 1'b0;
                we_q       <= 1'b0;
                addr_q     <= 12'd0;
                wdata_q    <= 8'd0;
                rdata_q    <= 8'd0;
            end else begin
                state_q    <= state_d;
                wait_cnt_q <= wait_cnt_d;
                err_q      <= err_d;
                we_q       <= we_d;
                addr_q     <= addr_d;
                wdata_q    <= wdata_d;
                rdata_q    <= rdata_d;
            end
        end

        assign core_ready[c]        = (state_q == ST_IDLE);
        assign core_done[c]         = (state_q == ST_DONE);
        assign core_err[c]          = (state_q == ST_DONE) && err_q;
        assign core_val[c]          = (state_q == ST_PEND);
        assign read[c]              = (state_q == ST_PEND) && !we_q;
        assign write[c]             = (state_q == ST_PEND) && we_q;
        assign addr_in[12*c +: 12]  = addr_q;
        assign data_in[8*c +: 8]    = wdata_q;
        assign core_rdata[8*c +: 8] = rdata_q;
    end

endmodule

// File: tb/tb_smem_req_tracker.sv
// Bench for smem_req_tracker: directed scenarios plus randomized traffic against a request-lifetime model.
module tb_smem_req_tracker;
    localparam int TO = 4;

    logic          clock;
    logic          reset;
    logic [15:0]   core_req, core_we;
    logic [191:0]  core_addr;
    logic [127:0]  core_wdata;
    logic [15:0]   core_ready, core_done, core_err, core_val, rd, wr;
    logic [127:0]  core_rdata;
    logic [191:0]  addr_in;
    logic [127:0]  data_in;
    logic [255:0]  bank_finish;
    logic [2047:0] bank_data;

    int total = 0;
    int bad   = 0;

    // Model: a request is "in flight" from its accept edge; it ends on a finish from its own bank
    // or when it has been in flight TO edges, and is reported during the following cycle.
    bit         m_act [16];
    bit         m_done[16];
    bit         m_err [16];
    bit         m_we  [16];
    int         m_age [16];
    logic [11:0] m_addr [16];
    logic [7:0]  m_wd   [16];
    logic [7:0]  m_rdata[16];

    smem_req_tracker #(.NCORES(16), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
        .core_val(core_val), .read(rd), .write(wr), .addr_in(addr_in), .data_in(data_in),
        .bank_finish(bank_finish), .bank_data(bank_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic model_reset();
        for (int c = 0; c < 16; c++) begin
            m_act[c] = 0; m_done[c] = 0; m_err[c] = 0; m_we[c] = 0; m_age[c] = 0;
            m_addr[c] = '0; m_wd[c] = '0; m_rdata[c] = '0;
        end
    endtask

    task automatic clear_inputs();
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        bank_finish = '0; bank_data = '0;
    endtask

    // Advance the model with the inputs present now, then take one clock edge.
    task automatic cyc();
        for (int c = 0; c < 16; c++) begin
            if (m_done[c]) begin
                m_done[c] = 0;
            end else if (!m_act[c]) begin
                if (core_req[c]) begin
                    m_act[c]  = 1;
                    m_age[c]  = 0;
                    m_we[c]   = core_we[c];
                    m_addr[c] = core_addr[12*c +: 12];
                    m_wd[c]   = core_wdata[8*c +: 8];
                end
            end else begin
                int b;
                b = int'(m_addr[c][11:8]);
                m_age[c] = m_age[c] + 1;
                if (bank_finish[16*b + c]) begin
                    m_act[c] = 0; m_done[c] = 1; m_err[c] = 0;
                    if (!m_we[c]) m_rdata[c] = bank_data[128*b + 8*c +: 8];
                end else if (m_age[c] == TO) begin
                    m_act[c] = 0; m_done[c] = 1; m_err[c] = 1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        total++; if (core_ready !== 16'hFFFF) begin bad++; $display("FAIL rst_ready got=%h exp=ffff", core_ready); end
        total++; if ({core_done, core_err} !== 32'h0) begin bad++; $display("FAIL rst_done_err got=%h exp=0", {core_done, core_err}); end
        total++; if ({core_val, rd, wr} !== 48'h0) begin bad++; $display("FAIL rst_val_rw got=%h exp=0", {core_val, rd, wr}); end
        total++; if (addr_in !== '0) begin bad++; $display("FAIL rst_addr_in got=%h exp=0", addr_in); end
        total++; if ({data_in, core_rdata} !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", {data_in, core_rdata}); end
        // First edge after release must accept: core 3 read of 0x5A7.
        @(negedge clock);
        reset = 1'b1;
        core_req[3] = 1'b1; core_we[3] = 1'b0; core_addr[36 +: 12] = 12'h5A7;
        cyc();
        core_req = '0;
        total++; if ({core_val[3], rd[3], wr[3], core_ready[3]} !== 4'b1100) begin bad++; $display("FAIL first_accept got=%b exp=1100", {core_val[3], rd[3], wr[3], core_ready[3]}); end
        total++; if (addr_in[36 +: 12] !== 12'h5A7) begin bad++; $display("FAIL first_addr_in got=%h exp=5a7", addr_in[36 +: 12]); end
    endtask

    task automatic test_read();
        bank_finish[83] = 1'b1;
        bank_data[128*5 + 24 +: 8] = 8'hC3;
        cyc();
        bank_finish = '0;
        total++; if ({core_done[3], core_err[3], core_val[3], core_ready[3]} !== 4'b1000) begin bad++; $display("FAIL read_done got=%b exp=1000", {core_done[3], core_err[3], core_val[3], core_ready[3]}); end
        total++; if (core_rdata[31:24] !== 8'hC3) begin bad++; $display("FAIL read_data got=%h exp=c3", core_rdata[31:24]); end
        cyc();
        total++; if ({core_done[3], core_ready[3]} !== 2'b01) begin bad++; $display("FAIL read_after got=%b exp=01", {core_done[3], core_ready[3]}); end
        total++; if (core_rdata[31:24] !== 8'hC3) begin bad++; $display("FAIL read_hold got=%h exp=c3", core_rdata[31:24]); end
    endtask

    task automatic test_write();
        logic [7:0] old;
        old = core_rdata[7:0];
        core_req[0] = 1'b1; core_we[0] = 1'b1; core_addr[11:0] = 12'h210; core_wdata[7:0] = 8'h44;
        cyc();
        clear_inputs();
        total++; if ({wr[0], rd[0]} !== 2'b10) begin bad++; $display("FAIL write_dir got=%b exp=10", {wr[0], rd[0]}); end
        total++; if ({addr_in[11:0], data_in[7:0]} !== 20'h21044) begin bad++; $display("FAIL write_lanes got=%h exp=21044", {addr_in[11:0], data_in[7:0]}); end
        cyc();
        total++; if ({wr[0], core_done[0]} !== 2'b10) begin bad++; $display("FAIL write_hold got=%b exp=10", {wr[0], core_done[0]}); end
        bank_finish[32] = 1'b1;
        bank_data[0 +: 8] = 8'hEE;
        bank_data[256 +: 8] = 8'hEE;
        cyc();
        clear_inputs();
        total++; if ({core_done[0], core_err[0], wr[0]} !== 3'b100) begin bad++; $display("FAIL write_done got=%b exp=100", {core_done[0], core_err[0], wr[0]}); end
        total++; if (core_rdata[7:0] !== old) begin bad++; $display("FAIL write_rdata got=%h exp=%h", core_rdata[7:0], old); end
        total++; if (data_in[7:0] !== 8'h44) begin bad++; $display("FAIL write_data_hold got=%h exp=44", data_in[7:0]); end
        cyc();
    endtask

    task automatic test_wrong_bank();
        core_req[7] = 1'b1; core_addr[84 +: 12] = 12'h233;
        cyc();
        clear_inputs();
        bank_finish[16*9 + 7] = 1'b1;
        cyc();
        bank_finish = '0;
        total++; if ({core_val[7], core_done[7]} !== 2'b10) begin bad++; $display("FAIL wrong_bank got=%b exp=10", {core_val[7], core_done[7]}); end
        bank_finish[16*2 + 7] = 1'b1;
        cyc();
        bank_finish = '0;
        total++; if ({core_done[7], core_err[7]} !== 2'b10) begin bad++; $display("FAIL right_bank got=%b exp=10", {core_done[7], core_err[7]}); end
        cyc();
    endtask

    task automatic test_timeout();
        core_req[5] = 1'b1; core_addr[60 +: 12] = 12'h100;
        cyc();
        clear_inputs();
        for (int k = 1; k <= TO; k++) begin
            cyc();
            if (k < TO) begin
                total++; if (core_done[5] !== 1'b0) begin bad++; $display("FAIL timeout_early k=%0d got=%b exp=0", k, core_done[5]); end
            end else begin
                total++; if ({core_done[5], core_err[5]} !== 2'b11) begin bad++; $display("FAIL timeout_done got=%b exp=11", {core_done[5], core_err[5]}); end
            end
        end
        cyc();
        total++; if ({core_done[5], core_ready[5]} !== 2'b01) begin bad++; $display("FAIL timeout_ready got=%b exp=01", {core_done[5], core_ready[5]}); end
        core_req[6] = 1'b1; core_addr[72 +: 12] = 12'hA00;
        cyc();
        clear_inputs();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) bank_finish[16*10 + 6] = 1'b1;
            cyc();
            bank_finish = '0;
        end
        total++; if ({core_done[6], core_err[6]} !== 2'b10) begin bad++; $display("FAIL finish_vs_timeout got=%b exp=10", {core_done[6], core_err[6]}); end
        cyc();
    endtask

    task automatic test_all_cores();
        int         cnt[16];
        logic [15:0] exp_mask;
        for (int c = 0; c < 16; c++) begin
            cnt[c] = 0;
            core_req[c] = 1'b1;
            core_addr[12*c +: 12] = {4'(c), 8'h00};
        end
        cyc();
        clear_inputs();
        total++; if (core_val !== 16'hFFFF) begin bad++; $display("FAIL all_val got=%h exp=ffff", core_val); end
        for (int g = 0; g < 4; g++) begin
            exp_mask = '0;
            for (int j = 0; j < 4; j++) begin
                int c;
                c = 15 - 4*g - j;
                bank_finish[16*c + c] = 1'b1;
                exp_mask[c] = 1'b1;
            end
            cyc();
            bank_finish = '0;
            for (int c = 0; c < 16; c++) cnt[c] += int'(core_done[c]);
            total++; if ({core_done, core_err} !== {exp_mask, 16'h0}) begin bad++; $display("FAIL all_order g=%0d got=%h exp=%h", g, {core_done, core_err}, {exp_mask, 16'h0}); end
        end
        cyc();
        for (int c = 0; c < 16; c++) cnt[c] += int'(core_done[c]);
        for (int c = 0; c < 16; c++) begin
            total++; if (cnt[c] !== 1) begin bad++; $display("FAIL all_once core=%0d got=%0d exp=1", c, cnt[c]); end
        end
    endtask

    task automatic test_async_reset();
        core_req[1] = 1'b1; core_addr[12 +: 12] = 12'h300; core_wdata[8 +: 8] = 8'h5D;
        cyc();
        clear_inputs();
        total++; if (core_val[1] !== 1'b1) begin bad++; $display("FAIL ar_pend got=%b exp=1", core_val[1]); end
        #3;
        reset = 1'b0;
        #1;
        total++; if ({core_ready, core_val, core_done} !== 48'hFFFF_0000_0000) begin bad++; $display("FAIL ar_ctrl got=%h exp=ffff00000000", {core_ready, core_val, core_done}); end
        total++; if ({addr_in, data_in, core_rdata} !== '0) begin bad++; $display("FAIL ar_data got=%h exp=0", {addr_in, data_in, core_rdata}); end
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            total++; if (core_done !== 16'h0) begin bad++; $display("FAIL ar_no_done k=%0d got=%h exp=0", k, core_done); end
        end
    endtask

    task automatic test_random();
        logic [15:0]  e_ready, e_done, e_err, e_val, e_rd, e_wr;
        logic [191:0] e_addr;
        logic [127:0] e_data, e_rdata;
        for (int it = 0; it < 400; it++) begin
            core_req = 16'($urandom);
            core_we  = 16'($urandom);
            for (int c = 0; c < 16; c++) begin
                core_addr[12*c +: 12] = 12'($urandom);
                core_wdata[8*c +: 8]  = 8'($urandom);
            end
            for (int i = 0; i < 256; i++) bank_finish[i] = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 64; i++) bank_data[32*i +: 32] = $urandom;
            cyc();
            for (int c = 0; c < 16; c++) begin
                e_ready[c] = !m_act[c] && !m_done[c];
                e_done[c]  = m_done[c];
                e_err[c]   = m_done[c] && m_err[c];
                e_val[c]   = m_act[c];
                e_rd[c]    = m_act[c] && !m_we[c];
                e_wr[c]    = m_act[c] && m_we[c];
                e_addr[12*c +: 12] = m_addr[c];
                e_data[8*c +: 8]   = m_wd[c];
                e_rdata[8*c +: 8]  = m_rdata[c];
            end
            total++; if (core_ready !== e_ready) begin bad++; $display("FAIL rnd_ready it=%0d got=%h exp=%h", it, core_ready, e_ready); end
            total++; if ({core_done, core_err} !== {e_done, e_err}) begin bad++; $display("FAIL rnd_done it=%0d got=%h exp=%h", it, {core_done, core_err}, {e_done, e_err}); end
            total++; if ({core_val, rd, wr} !== {e_val, e_rd, e_wr}) begin bad++; $display("FAIL rnd_qual it=%0d got=%h exp=%h", it, {core_val, rd, wr}, {e_val, e_rd, e_wr}); end
            total++; if (addr_in !== e_addr) begin bad++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, addr_in, e_addr); end
            total++; if (data_in !== e_data) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, data_in, e_data); end
            total++; if (core_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, core_rdata, e_rdata); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wrong_bank();
        test_timeout();
        test_all_cores();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/smem_req_tracker.md
SMEM_REQ_TRACKER -- requirements
Module: smem_req_tracker

Interface
REQ-001 Parameter NCORES, 16, number of cores and of bank arbiters (one bank per 4-bit bank number).
REQ-002 Parameter TIMEOUT, 255, maximum PEND cycles before a request is aborted (1..255).
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 core_req  in  16  per-core request; bit c is sampled only while core_ready[c]=1.
REQ-006 core_we  in  16  per-core direction: 1 = write, 0 = read.
REQ-007 core_addr  in  192  per-core 12-bit address at [12c+11:12c]; [11:8] is the bank and [7:0] is the offset.
REQ-008 core_wdata  in  128  per-core write byte at [8c+7:8c].
REQ-009 core_ready  out  16  core c may issue a request.
REQ-010 core_done  out  16  one-cycle completion pulse per core.
REQ-011 core_err  out  16  valid with core_done: 1 = timed out.
REQ-012 core_rdata  out  128  per-core read byte; holds its value until the next read completes.
REQ-013 core_val, read, write  out  16 each  broadcast request qualifiers to all bank arbiters.
REQ-014 addr_in  out  192  and  data_in  out  128  broadcast latched address and data, same packing as core_addr and core_wdata.
REQ-015 bank_finish  in  256  finish vector of bank b at [16b+15:16b].
REQ-016 bank_data  in  2048  data_out of bank b at [128b+127:128b].

Function
REQ-017 Each core has an independent 2-bit FSM with states IDLE, PEND, DONE.
REQ-018 core_ready[c] SHALL be 1 only in IDLE.
REQ-019 IDLE -> PEND on core_req[c]=1; the same edge latches we, the 12-bit address, the write byte, and clears wait_cnt[c] to 0.
REQ-020 In PEND: core_val[c]=1; read[c] = !we; write[c] = we; addr_in and data_in lanes for core c carry the latched values.
REQ-021 In IDLE and DONE: core_val, read and write bits for core c are 0; the addr_in and data_in lanes hold their last latched values.
REQ-022 Finish for core c = bank_finish[16*B+c], where B is the latched bank field; finish bits from any other bank are ignored.
REQ-023 PEND -> DONE on finish for core c; on the same edge, if the request is a read, core_rdata[8c+7:8c] <= bank_data[128B+8c+7 : 128B+8c].
REQ-024 On a write completion, core_rdata for core c SHALL be unchanged.
REQ-025 In PEND without finish, the 8-bit wait_cnt[c] increments by 1 per cycle.
REQ-026 When wait_cnt[c] = TIMEOUT-1 and finish is absent, the FSM SHALL go PEND -> DONE with the error flag set.
REQ-027 If finish and timeout occur in the same cycle, finish SHALL win and err = 0.
REQ-028 In DONE: core_done[c]=1 and core_err[c] = the error flag for exactly one cycle, then unconditionally -> IDLE.
REQ-029 Latency: request accepted at edge N gives core_val from cycle N+1; finish sampled at edge M gives core_done in cycle M+1 and core_ready in cycle M+2.
REQ-030 core_req during PEND or DONE SHALL be ignored (no queuing).
REQ-031 Finish arriving in IDLE or DONE SHALL be ignored.
REQ-032 The 16 cores SHALL operate fully concurrently, with no inter-core priority.

Reset
REQ-033 reset=0 SHALL immediately (asynchronously) force every FSM to IDLE and clear wait_cnt, the error flags and the latched we/address/data.
REQ-034 During reset=0: core_ready = 16'hFFFF; core_done, core_err, core_val, read and write = 0; addr_in, data_in and core_rdata = 0.
REQ-035 Reset asserted while any core is in PEND SHALL abort that request without producing core_done.
REQ-036 After reset deasserts, the first request SHALL be accepted on the first rising edge.

Verification
REQ-037 Core 3 read, addr 12'h5A7, bank 5 drives bank_finish[83]=1 and bank_data[128*5+31:128*5+24]=8'hC3 -> core_rdata[31:24]=8'hC3, core_done[3]=1 for one cycle, core_err[3]=0.
REQ-038 Core 0 write, addr 12'h210, wdata 8'h44 -> write[0]=1, addr_in[11:0]=12'h210, data_in[7:0]=8'h44 until finish; core_rdata unchanged.
REQ-039 Core 7 pending on bank 2, bank 9 pulses finish bit 7 -> ignored, core stays PEND; bank 2 pulses finish bit 7 -> completes.
REQ-040 No finish, TIMEOUT=4 -> core_done with core_err=1 exactly 5 cycles after the accept edge; finish and timeout in the same cycle -> err=0.
REQ-041 All 16 cores request on one edge, banks finish in reverse order -> each core_done pulses once, in the finish order.
REQ-042 reset=0 asserted mid-PEND, between clock edges -> outputs reach their reset values immediately; no core_done pulse follows after release.
